if_id_buffer: RTL and testbench

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 89 ++++++++
 tb/tb_if_id_buffer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small circular FIFO of fetched {pc, pc4, inst} entries
// that decouples the fetch stage from a decode stage that may stall.
module if_id_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     if_valid,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_pc4,
    input  logic [31:0]              if_inst,
    output logic                     if_ready,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_pc4,
    output logic [31:0]              id_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push, pop;

    // Handshakes depend only on registered occupancy, so a full buffer ignores
    // if_valid even when a pop happens in the same cycle.
    assign if_ready = (count_q < FULL);
    assign id_valid = (count_q != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; it is only ever seen through a valid head.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{pc: if_pc, pc4: if_pc4, inst: if_inst};
    end

    assign head    = id_valid ? mem_q[rd_ptr_q] : '0;
    assign id_pc   = head.pc;
    assign id_pc4  = head.pc4;
    assign id_inst = head.inst;
    assign count   = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: directed scenarios plus random traffic, all checked
// against a queue-based FIFO model of the buffer's contents.
module tb_if_id_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst, flush, if_valid, id_ready;
    logic [31:0] if_pc, if_pc4, if_inst;
    logic        if_ready, id_valid;
    logic [31:0] id_pc, id_pc4, id_inst;
    logic [$clog2(DEPTH):0] count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    ent_t        model_q[$];
    logic [31:0] popped_q[$];
    bit          last_push;
    int          total  = 0;
    int          passed = 0;

    if_id_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid),
        .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst), .if_ready(if_ready),
        .id_ready(id_ready), .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4),
        .id_inst(id_inst), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Compare every output against what the queue model says the buffer holds.
    task automatic check_model(input string tag);
        int   n = model_q.size();
        ent_t h = (n != 0) ? model_q[0] : '0;
        check({tag, ".count"},    32'(count),    32'(n));
        check({tag, ".if_ready"}, 32'(if_ready), 32'(n < DEPTH));
        check({tag, ".id_valid"}, 32'(id_valid), 32'(n != 0));
        check({tag, ".id_pc"},    id_pc,         h.pc);
        check({tag, ".id_pc4"},   id_pc4,        h.pc4);
        check({tag, ".id_inst"},  id_inst,       h.inst);
    endtask

    // One clock: apply inputs, check pre-edge state at negedge, step model at posedge.
    task automatic cycle(input string tag, input bit r, input bit f, input bit v,
                         input logic [31:0] pc, input logic [31:0] inst, input bit rdy);
        bit do_push, do_pop;
        rst = r; flush = f; if_valid = v; id_ready = rdy;
        if_pc = pc; if_pc4 = pc + 32'd4; if_inst = inst;
        @(negedge clk);
        check_model(tag);
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!r && !f) begin
            do_pop  = (model_q.size() > 0) && rdy;
            do_push = v && (model_q.size() < DEPTH);
        end
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                popped_q.push_back(model_q[0].pc);
                void'(model_q.pop_front());
            end
            if (do_push) model_q.push_back('{pc: pc, pc4: pc + 32'd4, inst: inst});
        end
        last_push = do_push;
        #1;
    endtask

    initial begin
        int k;
        rst = 1'b1; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b0;
        if_pc = '0; if_pc4 = '0; if_inst = '0;
        @(posedge clk); #1;
        cycle("reset", 1, 0, 0, 0, 0, 0);
        check("reset.count",    32'(count),    32'd0);
        check("reset.if_ready", 32'(if_ready), 32'd1);
        check("reset.id_valid", 32'(id_valid), 32'd0);
        check("reset.id_inst",  id_inst,       32'd0);

        // Streaming: id_pc trails if_pc by one cycle, occupancy stays at 1.
        for (int i = 0; i < 8; i++) cycle("stream", 0, 0, 1, 32'(4 * i), 32'h1000 + 32'(i), 1);
        check("stream.count", 32'(count), 32'd1);
        check("stream.id_pc", id_pc,      32'd28);
        cycle("drain", 0, 0, 0, 0, 0, 1);

        // Stall then release.
        cycle("stall", 0, 0, 1, 32'h100, 32'h20010005, 0);
        cycle("stall", 0, 0, 1, 32'h104, 32'h20020006, 0);
        check("stall.count",    32'(count),    32'd2);
        check("stall.if_ready", 32'(if_ready), 32'd0);
        check("stall.id_inst",  id_inst,       32'h20010005);
        cycle("release", 0, 0, 0, 0, 0, 1);
        check("release.id_inst", id_inst, 32'h20020006);
        cycle("release", 0, 0, 0, 0, 0, 1);
        check("release.if_ready", 32'(if_ready), 32'd1);

        // Full with simultaneous pop: input must not be captured.
        cycle("fill", 0, 0, 1, 32'h120, 32'h11, 0);
        cycle("fill", 0, 0, 1, 32'h124, 32'h22, 0);
        cycle("fullpop", 0, 0, 1, 32'h200, 32'hAAAA, 1);
        check("fullpop.count",   32'(count), 32'd1);
        check("fullpop.id_inst", id_inst,    32'h22);
        cycle("fullpop2", 0, 0, 0, 0, 0, 1);
        check("fullpop2.count",  32'(count), 32'd0);

        // Flush discards contents and the concurrent 0x40 fetch.
        cycle("fill", 0, 0, 1, 32'h130, 32'h33, 0);
        cycle("fill", 0, 0, 1, 32'h134, 32'h44, 0);
        cycle("flush", 0, 1, 1, 32'h40, 32'h55, 1);
        check("flush.count",    32'(count),    32'd0);
        check("flush.id_valid", 32'(id_valid), 32'd0);
        check("flush.id_inst",  id_inst,       32'd0);
        check("flush.if_ready", 32'(if_ready), 32'd1);
        cycle("postflush", 0, 0, 0, 0, 0, 1);

        // Wrap-around: 5 entries through DEPTH=2 under alternating id_ready.
        popped_q.delete();
        k = 0;
        for (int c = 0; c < 40 && (k < 5 || model_q.size() != 0); c++) begin
            cycle("wrap", 0, 0, k < 5, 32'h300 + 32'(4 * k), 32'h900 + 32'(k), c[0]);
            if (last_push) k++;
        end
        check("wrap.npop", 32'(popped_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < popped_q.size(); i++)
            check("wrap.order", popped_q[i], 32'h300 + 32'(4 * i));

        // Reset while full, with flush asserted too.
        cycle("fill", 0, 0, 1, 32'h140, 32'h66, 0);
        cycle("fill", 0, 0, 1, 32'h144, 32'h77, 0);
        cycle("midrst", 1, 1, 1, 32'h148, 32'h88, 1);
        check("midrst.count",    32'(count),    32'd0);
        check("midrst.if_ready", 32'(if_ready), 32'd1);
        check("midrst.id_pc",    id_pc,         32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle("rand", $urandom_range(63) == 0, $urandom_range(15) == 0,
                  $urandom_range(1) == 1, $urandom & 32'hFFFF_FFFC, $urandom,
                  $urandom_range(3) != 0);
        cycle("final", 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
